// File: rtl/uart_msg_tx.sv
// -----------------------------------------------------------------------------
// uart_msg_tx
//
// Push-button triggered UART message transmitter. A rising edge on the
// (asynchronous) button sends a fixed MSG_LEN-byte message from the MSG
// parameter, framed as 8 data bits LSB first, an optional odd/even parity
// bit and one or two stop bits. The baud rate comes from an internal
// divider. With REPEAT=1 the message loops, with GAP_BITS idle bit-times
// between passes, until abort is raised. Abort always lets the character
// on the line finish, so the receiver never sees a truncated frame.
//
// Parameters
//   CLK_HZ, BAUD  clock and line rate; DIV = round(CLK_HZ/BAUD) must be >= 2
//   MSG_LEN, MSG  message length in bytes (>= 1); byte 0 is MSG's top byte
//   PARITY        0 none, 1 odd, 2 even
//   STOP_BITS     1 or 2
//   REPEAT        0 one pass per press, 1 loop until abort
//   GAP_BITS      idle bit-times between passes when REPEAT=1
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   btn       raw push-button, asynchronous to clk
//   abort     stop request (level, synchronous to clk)
//   out_tx    UART line, idle high
//   busy      high from the first start bit until the return to IDLE
//   done      one-clk pulse at the end of the last stop bit of a pass
//   byte_idx  index of the byte currently being framed
// -----------------------------------------------------------------------------
module uart_msg_tx #(
  parameter int                   CLK_HZ    = 25000000,
  parameter int                   BAUD      = 9600,
  parameter int                   MSG_LEN   = 11,
  parameter logic [8*MSG_LEN-1:0] MSG       = 88'h69206C696B652046504741,
  parameter int                   PARITY    = 0,
  parameter int                   STOP_BITS = 1,
  parameter int                   REPEAT    = 0,
  parameter int                   GAP_BITS  = 4,
  localparam int                  IDX_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             abort,
  output logic             out_tx,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] byte_idx
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // Rounded divider: every bit lasts exactly DIV clocks.
  localparam int DIV      = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int GAP_CLKS = GAP_BITS * DIV;
  localparam int CNT_MAX  = (GAP_CLKS > DIV) ? GAP_CLKS : DIV;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam bit HAS_GAP  = (GAP_BITS > 0);

  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = HAS_GAP ? CNT_W'(GAP_CLKS - 1) : '0;
  localparam logic [2:0]       LAST_STOP  = 3'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Byte idx of the message; shifting left brings the wanted byte to the top.
  function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx);
    logic [8*MSG_LEN-1:0] m;
    m = MSG << (8 * idx);
    return m[8*MSG_LEN-1 -: 8];
  endfunction

  // Odd parity makes the total count of ones odd, hence the inverted XOR.
  function automatic logic parity_of(input logic [7:0] b);
    return (PARITY == 1) ? ~^b : ^b;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       bit_q,       bit_d;
  logic [7:0]       shift_q,     shift_d;
  logic [IDX_W-1:0] byte_idx_q,  byte_idx_d;
  logic             abort_q,     abort_d;
  logic             abort_pre_q, abort_pre_d;   // abort seen outside STOP
  logic             out_tx_q,    out_tx_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             s0_q, s1_q, s2_q;

  logic             start;
  logic             tick;
  logic             abort_now;
  logic             last_byte;
  logic             load_start;
  logic [IDX_W-1:0] load_idx;
  logic             go_idle;

  // s0/s1 resynchronise the raw button; s2 is one cycle older for the edge.
  assign start     = s1_q & ~s2_q;
  assign tick      = (cnt_q == '0);
  assign abort_now = abort_q | abort;
  assign last_byte = (MSG_LEN == 1) ? 1'b1 : (byte_idx_q == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_idx_d  = byte_idx_q;
    abort_d     = abort_q;
    abort_pre_d = abort_pre_q;
    out_tx_d    = out_tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_start  = 1'b0;
    load_idx    = '0;
    go_idle     = 1'b0;

    // While busy the bit timer runs and abort is latched until IDLE.
    if (state_q != S_IDLE) begin
      cnt_d   = cnt_q - CNT_W'(1);
      abort_d = abort_now;
      if (abort && (state_q != S_STOP)) begin
        abort_pre_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        out_tx_d = 1'b1;
        busy_d   = 1'b0;
        // Abort is not looked at here, so start wins over a same-cycle abort.
        if (start) begin
          load_start  = 1'b1;
          load_idx    = '0;
          abort_d     = 1'b0;
          abort_pre_d = 1'b0;
        end
      end

      S_START: begin
        if (tick) begin
          state_d  = S_DATA;
          cnt_d    = BIT_RELOAD;
          bit_d    = '0;
          out_tx_d = shift_q[0];
        end
      end

      // shift_q[0] is always the bit currently on the line.
      S_DATA: begin
        if (tick) begin
          cnt_d = BIT_RELOAD;
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d  = S_PARITY;
              out_tx_d = parity_of(msg_byte(byte_idx_q));
            end else begin
              state_d  = S_STOP;
              out_tx_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            out_tx_d = shift_q[1];
          end
        end
      end

      S_PARITY: begin
        if (tick) begin
          state_d  = S_STOP;
          cnt_d    = BIT_RELOAD;
          bit_d    = '0;
          out_tx_d = 1'b1;
        end
      end

      S_STOP: begin
        if (tick) begin
          if (bit_q == LAST_STOP) begin
            if (abort_now) begin
              // An abort that only arrived during the final byte's stop bits
              // still lets that pass count as complete.
              if (last_byte && !abort_pre_q) begin
                done_d = 1'b1;
              end
              go_idle = 1'b1;
            end else if (!last_byte) begin
              load_start = 1'b1;
              load_idx   = byte_idx_q + IDX_W'(1);
            end else begin
              done_d = 1'b1;
              if (REPEAT != 0) begin
                if (HAS_GAP) begin
                  state_d  = S_GAP;
                  cnt_d    = GAP_RELOAD;
                  out_tx_d = 1'b1;
                end else begin
                  load_start = 1'b1;
                  load_idx   = '0;
                end
              end else begin
                go_idle = 1'b1;
              end
            end
          end else begin
            bit_d = bit_q + 3'd1;
            cnt_d = BIT_RELOAD;
          end
        end
      end

      S_GAP: begin
        if (tick) begin
          if (abort_now) begin
            go_idle = 1'b1;
          end else begin
            load_start = 1'b1;
            load_idx   = '0;
          end
        end
      end

      default: go_idle = 1'b1;
    endcase

    // Common START entry: fetch the byte and put the start bit on the line.
    if (load_start) begin
      state_d    = S_START;
      byte_idx_d = load_idx;
      shift_d    = msg_byte(load_idx);
      cnt_d      = BIT_RELOAD;
      bit_d      = '0;
      out_tx_d   = 1'b0;
      busy_d     = 1'b1;
    end

    if (go_idle) begin
      state_d     = S_IDLE;
      byte_idx_d  = '0;
      cnt_d       = '0;
      bit_d       = '0;
      out_tx_d    = 1'b1;
      busy_d      = 1'b0;
      abort_d     = 1'b0;
      abort_pre_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous, so it is tested inside the clocked block
  // rather than listed in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_idx_q  <= '0;
      abort_q     <= 1'b0;
      abort_pre_q <= 1'b0;
      out_tx_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      byte_idx_q  <= byte_idx_d;
      abort_q     <= abort_d;
      abort_pre_q <= abort_pre_d;
      out_tx_q    <= out_tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s0_q        <= btn;
      s1_q        <= s0_q;
      s2_q        <= s1_q;
    end
  end

  assign out_tx   = out_tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign byte_idx = byte_idx_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_msg_tx
//
// Bench for uart_msg_tx. Six instances with different framing options run
// at DIV=16 and share one reset; sel picks the instance under test. Every
// press pushes the expected line bits and bytes onto scoreboard queues; a
// receiver samples mid-bit and pops/compares. Table vectors cover the
// framing variants; hand-written sequences cover repeat/gap/abort, a held
// button and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_uart_msg_tx;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] btn_v   = '0;
  logic [5:0] abort_v = '0;
  wire  [5:0] tx_v, busy_v, done_v;
  wire  [0:0] idx0, idx1, idx2, idx3, idx4;
  wire  [3:0] idx5;

  logic [2:0] sel = '0;
  logic       tx_m, busy_m, done_m;
  logic [3:0] idx_m;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  bit         exp_q[$];
  logic [7:0] exp_byte_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_msg_tx #(.CLK_HZ(160), .BAUD(10), .MSG_LEN(2), .MSG(16'hA53C),
    .PARITY(0), .STOP_BITS(1), .REPEAT(0), .GAP_BITS(4)) u_base (
    .clk(clk), .rst(rst), .btn(btn_v[0]), .abort(abort_v[0]), .out_tx(tx_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .byte_idx(idx0));

  uart_msg_tx #(.CLK_HZ(160), .BAUD(10), .MSG_LEN(2), .MSG(16'hA53C),
    .PARITY(2), .STOP_BITS(1), .REPEAT(0), .GAP_BITS(4)) u_even (
    .clk(clk), .rst(rst), .btn(btn_v[1]), .abort(abort_v[1]), .out_tx(tx_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .byte_idx(idx1));

  uart_msg_tx #(.CLK_HZ(160), .BAUD(10), .MSG_LEN(2), .MSG(16'hA53C),
    .PARITY(1), .STOP_BITS(1), .REPEAT(0), .GAP_BITS(4)) u_odd (
    .clk(clk), .rst(rst), .btn(btn_v[2]), .abort(abort_v[2]), .out_tx(tx_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .byte_idx(idx2));

  uart_msg_tx #(.CLK_HZ(160), .BAUD(10), .MSG_LEN(2), .MSG(16'hA53C),
    .PARITY(0), .STOP_BITS(2), .REPEAT(0), .GAP_BITS(4)) u_stop2 (
    .clk(clk), .rst(rst), .btn(btn_v[3]), .abort(abort_v[3]), .out_tx(tx_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .byte_idx(idx3));

  uart_msg_tx #(.CLK_HZ(160), .BAUD(10), .MSG_LEN(2), .MSG(16'hA53C),
    .PARITY(0), .STOP_BITS(1), .REPEAT(1), .GAP_BITS(4)) u_rep (
    .clk(clk), .rst(rst), .btn(btn_v[4]), .abort(abort_v[4]), .out_tx(tx_v[4]),
    .busy(busy_v[4]), .done(done_v[4]), .byte_idx(idx4));

  // Default message and framing, only the clock ratio scaled down to DIV=16.
  uart_msg_tx #(.CLK_HZ(160), .BAUD(10)) u_msg (
    .clk(clk), .rst(rst), .btn(btn_v[5]), .abort(abort_v[5]), .out_tx(tx_v[5]),
    .busy(busy_v[5]), .done(done_v[5]), .byte_idx(idx5));

  always_comb begin
    tx_m   = tx_v[sel];
    busy_m = busy_v[sel];
    done_m = done_v[sel];
    case (sel)
      3'd0:    idx_m = {3'b000, idx0};
      3'd1:    idx_m = {3'b000, idx1};
      3'd2:    idx_m = {3'b000, idx2};
      3'd3:    idx_m = {3'b000, idx3};
      3'd4:    idx_m = {3'b000, idx4};
      3'd5:    idx_m = idx5;
      default: idx_m = '0;
    endcase
  end

  typedef struct {
    int         sel;
    int         len;
    logic [87:0] msg;
    int         par;
    int         stop;
    bit         abort_at_start;
    bit         busy_press;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, dut %0d)", name, act, exp, cyc, sel);
    end
  endtask

  // Returns at the falling edge after rising edge number c.
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_pulse(output int t0);
    automatic int s = sel;
    t0 = cyc + 1;
    btn_v[s] = 1'b1;
    fork
      begin
        repeat (5) @(negedge clk);
        btn_v[s] = 1'b0;
      end
    join_none
  endtask

  task automatic push_pass(input int len, input logic [87:0] msg, input int par, input int stop);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'(msg >> (8 * (len - 1 - i)));
      exp_byte_q.push_back(b);
      exp_q.push_back(1'b0);
      for (int j = 0; j < 8; j++) exp_q.push_back(b[j]);
      if (par == 1) exp_q.push_back(~^b);
      else if (par == 2) exp_q.push_back(^b);
      for (int j = 0; j < stop; j++) exp_q.push_back(1'b1);
    end
  endtask

  // Watches one pass whose button edge was sampled at edge t0.
  task automatic check_pass(input int t0, input int fbits, input int len, input int exp_done,
                            input int busy_end, input int busy_pre, input int last_c);
    int         base;
    int         end_c;
    int         ndone;
    int         k;
    int         pos;
    bit         e;
    logic [7:0] rx;
    base  = t0 + 2;
    end_c = base + DIV * fbits * len;
    ndone = 0;
    rx    = '0;
    for (int c = t0 + 1; c <= end_c + 1 && c <= last_c; c++) begin
      wait_to(c);
      if (done_m) ndone++;
      if (c == t0 + 1) begin
        check("tx_high_before_start", 32'(tx_m), 32'd1);
        check("busy_before_start", 32'(busy_m), 32'(busy_pre));
      end
      if (c == base) begin
        check("start_bit_edge", 32'(tx_m), 32'd0);
        check("busy_at_start", 32'(busy_m), 32'd1);
      end
      if (c >= base && c < end_c && ((c - base) % (DIV * fbits)) == 0)
        check("byte_idx", 32'(idx_m), 32'((c - base) / (DIV * fbits)));
      if (c >= base && c < end_c && ((c - base) % DIV) == DIV / 2) begin
        k   = (c - base) / DIV;
        pos = k % fbits;
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("line_bit", 32'(tx_m), 32'(e));
        end
        if (pos >= 1 && pos <= 8) rx[pos-1] = tx_m;
        if (pos == 8) begin
          if (exp_byte_q.size() == 0) check("byte_queue_empty", 32'd1, 32'd0);
          else check("rx_byte", 32'(rx), 32'(exp_byte_q.pop_front()));
        end
      end
      if (c == end_c - 1) begin
        check("busy_before_end", 32'(busy_m), 32'd1);
        check("done_early", 32'(done_m), 32'd0);
      end
      if (c == end_c) begin
        check("done_count", 32'(ndone), 32'(exp_done));
        check("busy_at_end", 32'(busy_m), 32'(busy_end));
      end
      if (c == end_c + 1) check("done_width", 32'(done_m), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    int   t0b;
    int   end1;
    int   end2;
    int   fb;
    vec_t v;

    vecs[0] = '{0, 2, 88'hA53C, 0, 1, 1'b0, 1'b0};
    vecs[1] = '{1, 2, 88'hA53C, 2, 1, 1'b0, 1'b0};
    vecs[2] = '{2, 2, 88'hA53C, 1, 1, 1'b0, 1'b0};
    vecs[3] = '{3, 2, 88'hA53C, 0, 2, 1'b0, 1'b0};
    vecs[4] = '{0, 2, 88'hA53C, 0, 1, 1'b1, 1'b1};
    vecs[5] = '{5, 11, 88'h69206C696B652046504741, 0, 1, 1'b0, 1'b0};

    // Reset state of every instance.
    do_reset();
    for (int s = 0; s < 6; s++) begin
      sel = 3'(s);
      #1;
      check("reset_tx", 32'(tx_m), 32'd1);
      check("reset_busy", 32'(busy_m), 32'd0);
      check("reset_done", 32'(done_m), 32'd0);
      check("reset_idx", 32'(idx_m), 32'd0);
    end

    // Table vectors: one full pass each.
    for (int i = 0; i < 6; i++) begin
      v   = vecs[i];
      sel = 3'(v.sel);
      fb  = 9 + ((v.par != 0) ? 1 : 0) + v.stop;
      do_reset();
      exp_q.delete();
      exp_byte_q.delete();
      press_pulse(t0);
      push_pass(v.len, v.msg, v.par, v.stop);
      fork
        check_pass(t0, fb, v.len, 1, 0, 0, 1_000_000);
        begin
          if (v.abort_at_start) begin
            wait_to(t0 + 1);
            abort_v[v.sel] = 1'b1;
            wait_to(t0 + 2);
            abort_v[v.sel] = 1'b0;
          end
          if (v.busy_press) begin
            wait_to(t0 + 49);
            btn_v[v.sel] = 1'b1;
            wait_to(t0 + 54);
            btn_v[v.sel] = 1'b0;
          end
        end
      join
      check("leftover_bits", 32'(exp_q.size()), 32'd0);
    end

    // Repeat: gap of 4 bit-times, then abort mid byte 1 of pass 2.
    sel = 3'd4;
    do_reset();
    exp_q.delete();
    exp_byte_q.delete();
    press_pulse(t0);
    push_pass(2, 88'hA53C, 0, 1);
    check_pass(t0, 10, 2, 1, 1, 0, 1_000_000);
    end1 = t0 + 2 + 320;
    for (int j = 0; j < 4; j++) begin
      wait_to(end1 + 8 + 16 * j);
      check("gap_line_high", 32'(tx_m), 32'd1);
      check("gap_busy", 32'(busy_m), 32'd1);
    end
    t0b = end1 + 62;
    push_pass(2, 88'hA53C, 0, 1);
    fork
      check_pass(t0b, 10, 2, 0, 0, 1, 1_000_000);
      begin
        wait_to(t0b + 2 + 240);
        abort_v[4] = 1'b1;
        wait_to(t0b + 2 + 244);
        abort_v[4] = 1'b0;
      end
    join
    end2 = t0b + 2 + 320;
    wait_to(end2 + 16);
    check("abort_idle_busy", 32'(busy_m), 32'd0);
    check("abort_idle_tx", 32'(tx_m), 32'd1);
    wait_to(end2 + 80);
    check("abort_no_restart", 32'(busy_m), 32'd0);

    // Button held across the return to IDLE must not retrigger.
    sel = 3'd0;
    do_reset();
    exp_q.delete();
    exp_byte_q.delete();
    t0 = cyc + 1;
    btn_v[0] = 1'b1;
    push_pass(2, 88'hA53C, 0, 1);
    check_pass(t0, 10, 2, 1, 0, 0, 1_000_000);
    wait_to(t0 + 322 + 20);
    check("held_btn_no_retrigger", 32'(busy_m), 32'd0);
    check("held_btn_tx", 32'(tx_m), 32'd1);
    btn_v[0] = 1'b0;

    // Reset at clk 100 of a pass, then a fresh press restarts from byte 0.
    do_reset();
    exp_q.delete();
    exp_byte_q.delete();
    press_pulse(t0);
    push_pass(2, 88'hA53C, 0, 1);
    check_pass(t0, 10, 2, 1, 0, 0, t0 + 99);
    rst = 1'b1;
    wait_to(t0 + 100);
    check("midreset_tx", 32'(tx_m), 32'd1);
    check("midreset_busy", 32'(busy_m), 32'd0);
    check("midreset_idx", 32'(idx_m), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_byte_q.delete();
    wait_to(t0 + 130);
    check("after_reset_idle", 32'(busy_m), 32'd0);
    press_pulse(t0);
    push_pass(2, 88'hA53C, 0, 1);
    check_pass(t0, 10, 2, 1, 0, 0, 1_000_000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
